// File: rtl/dword_cmd_issuer_pkg.sv
// rtl/dword_cmd_issuer_pkg.sv - header dword layout, sequencer states and timing constants
package dword_cmd_issuer_pkg;

  localparam int DIN_LSB      = 0;
  localparam int DIN_W        = 12;
  localparam int DOUT_LSB     = 12;
  localparam int DOUT_W       = 12;
  localparam int LEN_LSB      = 24;
  localparam int LEN_W        = 7;
  localparam int QUAD_BIT     = 31;
  localparam int QUAD_W       = 1;
  localparam int BLANK_CYCLES = 2;
  localparam int TIMER_W      = 25;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    HDR,
    PAY,
    WAIT_DONE
  } state_t;

  function automatic logic [31:0] build_header(
    input logic              quad,
    input logic [LEN_W-1:0]  len,
    input logic [DOUT_W-1:0] dout,
    input logic [DIN_W-1:0]  din
  );
    logic [31:0] hdr;
    hdr                       = '0;
    hdr[DIN_LSB +: DIN_W]     = din;
    hdr[DOUT_LSB +: DOUT_W]   = dout;
    hdr[LEN_LSB +: LEN_W]     = len;
    hdr[QUAD_BIT +: QUAD_W]   = quad;
    return hdr;
  endfunction

endpackage

// File: rtl/dword_cmd_issuer_fifo.sv
// rtl/dword_cmd_issuer_fifo.sv - payload dword FIFO with first-word fall-through read and clear
module dword_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [31:0]   i_data,
  input  logic          i_pop,
  output logic [31:0]   o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk_in) begin
    if (reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/dword_cmd_issuer.sv
// rtl/dword_cmd_issuer.sv - issues header + buffered payload dwords to the QSPI dword interface
module dword_cmd_issuer
  import dword_cmd_issuer_pkg::*;
#(
  parameter int MAX_DWORDS     = 8,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic        quad_in,
  input  logic [11:0] din_count,
  input  logic [11:0] dout_count,
  input  logic        pl_wr,
  input  logic [31:0] pl_data,
  output logic        pl_full,
  output logic        ready,
  output logic        done,
  output logic [63:0] result,
  output logic        cmd_error,
  output logic        timeout,
  output logic        if_wr,
  output logic [31:0] if_data,
  input  logic        if_busy,
  input  logic        if_error,
  input  logic [63:0] if_readout
);

  localparam int CNT_W = $clog2(MAX_DWORDS + 1);

  state_t              r_state;
  state_t              w_next;
  logic [TIMER_W-1:0]  r_timer;
  logic                r_quad;
  logic [DIN_W-1:0]    r_din;
  logic [DOUT_W-1:0]   r_dout;
  logic [LEN_W-1:0]    r_len;
  logic [31:0]         r_if_data;
  logic                r_done;
  logic [63:0]         r_result;
  logic                r_cmd_error;
  logic                r_timeout;

  logic                w_accept;
  logic                w_push;
  logic                w_push_ok;
  logic [LEN_W-1:0]    w_len_now;
  logic                w_timer_exp;
  logic                w_blank_over;
  logic                w_hdr_load;
  logic                w_pop;
  logic                w_clear;
  logic                w_finish;
  logic                w_abort;
  logic                w_if_wr;
  logic [31:0]         w_fifo_data;
  logic [CNT_W-1:0]    w_fifo_count;
  logic                w_fifo_full;
  logic                w_fifo_empty;

  assign w_accept     = (r_state == IDLE) && start;
  assign w_push       = pl_wr && (r_state == IDLE);
  assign w_push_ok    = w_push && !w_fifo_full;
  // A push in the acceptance cycle still belongs to this command.
  assign w_len_now    = LEN_W'(w_fifo_count) + LEN_W'(w_push_ok);
  assign w_timer_exp  = (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign w_blank_over = (r_timer >= TIMER_W'(BLANK_CYCLES));
  assign w_hdr_load   = (r_state == WAIT_RDY) && !if_busy;

  dword_fifo #(.DEPTH(MAX_DWORDS), .CW(CNT_W)) u_fifo (
    .clk_in  (clk_in),
    .reset   (reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_data  (pl_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_clear  = 1'b0;
    w_finish = 1'b0;
    w_abort  = 1'b0;
    w_if_wr  = 1'b0;
    case (r_state)
      IDLE:      if (start) w_next = WAIT_RDY;
      WAIT_RDY:  if (!if_busy) w_next = HDR;
                 else if (w_timer_exp) w_abort = 1'b1;
      HDR: begin
        w_if_wr = 1'b1;
        if (r_len != '0) begin
          w_next = PAY;
          w_pop  = 1'b1;
        end else begin
          w_next = WAIT_DONE;
        end
      end
      PAY: begin
        w_if_wr = 1'b1;
        if (!w_fifo_empty) begin
          w_pop = 1'b1;
        end else begin
          w_next  = WAIT_DONE;
          w_clear = 1'b1;
        end
      end
      // Busy only rises after the header, so its first cycles here are not trusted.
      WAIT_DONE: if (w_blank_over && !if_busy) begin
                   w_finish = 1'b1;
                   w_next   = IDLE;
                 end else if (w_timer_exp) begin
                   w_abort = 1'b1;
                 end
      default:   w_next = IDLE;
    endcase
    if (w_abort) begin
      w_next  = IDLE;
      w_clear = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_quad <= 1'b0;
      r_din  <= '0;
      r_dout <= '0;
      r_len  <= '0;
    end else if (w_accept) begin
      r_quad <= quad_in;
      r_din  <= din_count;
      r_dout <= dout_count;
      r_len  <= w_len_now;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset || w_accept || (w_next == WAIT_DONE && r_state != WAIT_DONE)) begin
      r_timer <= '0;
    end else if ((r_state == WAIT_RDY || r_state == WAIT_DONE) && r_timer != '1) begin
      r_timer <= r_timer + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_if_data   <= '0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_cmd_error <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done <= w_finish || w_abort;
      if (w_hdr_load)  r_if_data <= build_header(r_quad, r_len, r_dout, r_din);
      else if (w_pop)  r_if_data <= w_fifo_data;
      if (w_finish) begin
        r_result    <= if_readout;
        r_cmd_error <= if_error;
      end
      if (w_accept)     r_timeout <= 1'b0;
      else if (w_abort) r_timeout <= 1'b1;
    end
  end

  assign pl_full   = w_fifo_full;
  assign ready     = (r_state == IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign cmd_error = r_cmd_error;
  assign timeout   = r_timeout;
  assign if_wr     = w_if_wr;
  assign if_data   = r_if_data;

endmodule

// File: doc/dword_cmd_issuer.md
Name: dword_cmd_issuer

Overview:
- On-chip initiator that drives the host-side dword command stream into the QSPI dword command interface.
- It lets fabric logic (self-update / boot FSM) issue flash commands without a PC.
- It buffers up to MAX_DWORDS payload dwords, builds the header dword, sequences header then payload on the write strobe, and waits for the interface to go idle.
- On completion it returns the 64-bit readout, the error flag and a done pulse.

Parameters:
- MAX_DWORDS, 8, payload FIFO depth in dwords; must be ≤127 (header len field is 7 bits).
- TIMEOUT_CYCLES, 2**24, max clk_in cycles allowed in WAIT_RDY or WAIT_DONE before abort.

Ports:
- clk_in  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  request a command; honoured only when ready=1
- quad_in  in  1  quad-mode flag, copied to header bit 31
- din_count  in  12  controller data_in_count, header [11:0]
- dout_count  in  12  controller data_out_count, header [23:12]
- pl_wr  in  1  push pl_data into payload FIFO
- pl_data  in  32  payload dword
- pl_full  out  1  FIFO holds MAX_DWORDS entries
- ready  out  1  state==IDLE
- done  out  1  one-cycle completion pulse
- result  out  64  readout captured at completion
- cmd_error  out  1  if_error captured at completion
- timeout  out  1  sticky; set on timeout abort, cleared by next accepted start
- if_wr  out  1  write strobe to interface
- if_data  out  32  dword to interface
- if_busy  in  1  interface busy
- if_error  in  1  interface error
- if_readout  in  64  interface readout

Behaviour:
- Reset values:
  - state=IDLE; if_wr=0; if_data=0; done=0; result=0; cmd_error=0; timeout=0.
  - FIFO emptied; pl_full=0; ready=1 the cycle after reset deasserts.
- Header format: {quad, len[6:0], dout_count, din_count}. len = FIFO count at acceptance (includes a pl_wr in the same cycle as start). din_count, dout_count and quad_in are latched at start.
- FIFO:
  - pl_wr accepted only in IDLE with count<MAX_DWORDS.
  - pl_wr when full or not IDLE is dropped silently; count unchanged.
  - First-written dword is sent first.
  - FIFO is emptied on leaving PAY and on any abort.
- States:
  - IDLE: start → WAIT_RDY, timeout cleared, timer=0.
  - WAIT_RDY: if_busy=0 → HDR. Timer expiry → abort.
  - HDR: exactly one cycle with if_wr=1, if_data=header. Next state is PAY if len>0, else WAIT_DONE.
  - PAY: if_wr=1 every cycle, one FIFO dword per cycle, len consecutive cycles with no gaps. After the last dword: if_wr=0 → WAIT_DONE, timer=0.
  - WAIT_DONE: ignore the first 2 cycles (blanking; interface busy rises the cycle after HDR). Then if_busy=0 → latch result=if_readout and cmd_error=if_error, done=1 for one cycle → IDLE. Timer expiry → abort.
  - abort: timeout=1, done=1 for one cycle, result and cmd_error unchanged, if_wr=0 → IDLE.
- Latency: with if_busy=0 at start, header appears 2 cycles after start is sampled (WAIT_RDY, then HDR).
- if_wr is 0 in every state except HDR and PAY. if_data holds its last value otherwise.
- start while not IDLE is ignored; it is not queued.
- Reset mid-operation: immediate return to reset values. if_wr drops in the same cycle reset is sampled.
- Timer: 25-bit saturating counter. Abort when timer==TIMEOUT_CYCLES-1.

Decomposition:
- Shared package holds:
  - header field positions: DIN_LSB=0, DOUT_LSB=12, LEN_LSB=24, QUAD_BIT=31, widths 12/12/7/1;
  - the state enum: IDLE, WAIT_RDY, HDR, PAY, WAIT_DONE;
  - the blanking constant of 2.
- One sub-module: dword_fifo (synchronous, depth MAX_DWORDS, count output, clear input).

Test Plan:
- Header only: din=4, dout=0, quad=0, no payload, if_busy=0, start → one if_wr cycle with if_data=0x00000004. Bench raises if_busy for 20 cycles → done, result=bench readout.
- Payload of two: push 0x06AB0000, 0x00000000; din=0, dout=8, quad=1, start → if_data sequence 0x82008000, 0x06AB0000, 0x00000000 on 3 consecutive if_wr cycles. result=0x0123456789ABCDEF after busy falls.
- if_busy held 1 for 50 cycles at start → no if_wr until busy=0, then header. An extra start during the wait is ignored.
- Overflow: 10 pushes with MAX_DWORDS=8 → pl_full=1 after the 8th; header len=8; only the first 8 dwords are sent.
- Timeout (TIMEOUT_CYCLES=64): if_busy stuck 1 after header → timeout=1, done pulse at cycle 64 of WAIT_DONE. The next start clears timeout.
- Reset asserted on the 2nd PAY cycle → if_wr=0 immediately, ready=1, FIFO empty (pl_full=0), done never pulsed.
